// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-request memory controller.
// Each port owns a one-deep request latch; one transaction is outstanding
// downstream at a time, and a watchdog forces completion if the controller stalls.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_data_in,
    input  logic                  p0_r_en,
    input  logic                  p0_w_en,
    output logic                  p0_rdy,
    output logic                  p0_cplt,
    output logic [DATA_WIDTH-1:0] p0_data_out,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_data_in,
    input  logic                  p1_r_en,
    input  logic                  p1_w_en,
    output logic                  p1_rdy,
    output logic                  p1_cplt,
    output logic [DATA_WIDTH-1:0] p1_data_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    input  logic                  mem_rdy,
    input  logic                  mem_cplt,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  err_timeout,
    output logic                  err_stray
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                       state_q, state_d;
    logic                         owner_q, owner_d;
    logic                         last_grant_q, last_grant_d;
    logic [WdW-1:0]               wdog_q, wdog_d;
    logic [1:0]                   pend_q, pend_d;
    logic [1:0]                   wr_q, wr_d;       // latched op: 1 = write, 0 = read
    logic [1:0][ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0][DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0][DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [1:0]                   cplt_q, cplt_d;
    logic                         err_timeout_q, err_timeout_d;
    logic                         err_stray_q, err_stray_d;
    logic                         done, timeout_hit;

    logic [1:0]                   req_r, req_w;
    logic [1:0][ADDR_WIDTH-1:0]   req_addr;
    logic [1:0][DATA_WIDTH-1:0]   req_data;

    assign req_r    = {p1_r_en, p0_r_en};
    assign req_w    = {p1_w_en, p0_w_en};
    assign req_addr = {p1_addr, p0_addr};
    assign req_data = {p1_data_in, p0_data_in};

    assign p0_rdy      = ~pend_q[0];
    assign p1_rdy      = ~pend_q[1];
    assign p0_cplt     = cplt_q[0];
    assign p1_cplt     = cplt_q[1];
    assign p0_data_out = dout_q[0];
    assign p1_data_out = dout_q[1];
    assign err_timeout = err_timeout_q;
    assign err_stray   = err_stray_q;

    // FSM state register, owner and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state: grant selection, downstream handshake, completion / watchdog
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wdog_d      = wdog_q;
        done        = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    state_d = StIssue;
                    // Tie goes to the port that was not granted last
                    owner_d = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
                end
            end
            StIssue: begin
                if (mem_rdy) begin
                    state_d = StWait;
                    wdog_d  = '0;
                end
            end
            StWait: begin
                wdog_d = wdog_q + WdW'(1);
                if (mem_cplt) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    done        = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers: request latches, read data, pulses, sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            wr_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            dout_q        <= '0;
            cplt_q        <= '0;
            last_grant_q  <= 1'b1;
            err_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            dout_q        <= dout_d;
            cplt_q        <= cplt_d;
            last_grant_q  <= last_grant_d;
            err_timeout_q <= err_timeout_d;
            err_stray_q   <= err_stray_d;
        end
    end

    // Datapath next-state: port accept and completion routing to the owner
    always_comb begin
        pend_d        = pend_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        dout_d        = dout_q;
        cplt_d        = '0;
        last_grant_d  = last_grant_q;
        err_timeout_d = err_timeout_q;
        err_stray_d   = err_stray_q;
        for (int n = 0; n < 2; n++) begin
            if (!pend_q[n] && (req_r[n] || req_w[n])) begin
                pend_d[n] = 1'b1;
                addr_d[n] = req_addr[n];
                data_d[n] = req_data[n];
                wr_d[n]   = req_w[n] & ~req_r[n];  // both enables high reads
            end
        end
        if (done) begin
            pend_d[owner_q] = 1'b0;
            cplt_d[owner_q] = 1'b1;
            last_grant_d    = owner_q;
            if (!wr_q[owner_q]) begin
                dout_d[owner_q] = timeout_hit ? '0 : mem_data_out;
            end
            if (timeout_hit) begin
                err_timeout_d = 1'b1;
            end
        end
        if (mem_cplt && (state_q != StWait)) begin
            err_stray_d = 1'b1;
        end
    end

    // Downstream outputs: owner latch during ISSUE, port 0 latch otherwise
    always_comb begin
        mem_addr    = addr_q[0];
        mem_data_in = data_q[0];
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        if (state_q == StIssue) begin
            mem_addr    = addr_q[owner_q];
            mem_data_in = data_q[owner_q];
            mem_r_en    = ~wr_q[owner_q];
            mem_w_en    = wr_q[owner_q];
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (watchdog shortened to 8 cycles).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] p0_addr, p0_data_in, p0_data_out;
    logic        p0_r_en, p0_w_en, p0_rdy, p0_cplt;
    logic [15:0] p1_addr, p1_data_in, p1_data_out;
    logic        p1_r_en, p1_w_en, p1_rdy, p1_cplt;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_r_en, mem_w_en, mem_rdy, mem_cplt;
    logic        err_timeout, err_stray;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_addr     (p0_addr),
        .p0_data_in  (p0_data_in),
        .p0_r_en     (p0_r_en),
        .p0_w_en     (p0_w_en),
        .p0_rdy      (p0_rdy),
        .p0_cplt     (p0_cplt),
        .p0_data_out (p0_data_out),
        .p1_addr     (p1_addr),
        .p1_data_in  (p1_data_in),
        .p1_r_en     (p1_r_en),
        .p1_w_en     (p1_w_en),
        .p1_rdy      (p1_rdy),
        .p1_cplt     (p1_cplt),
        .p1_data_out (p1_data_out),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .mem_rdy     (mem_rdy),
        .mem_cplt    (mem_cplt),
        .mem_data_out(mem_data_out),
        .err_timeout (err_timeout),
        .err_stray   (err_stray)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_addr = '0; p0_data_in = '0; p0_r_en = 1'b0; p0_w_en = 1'b0;
        p1_addr = '0; p1_data_in = '0; p1_r_en = 1'b0; p1_w_en = 1'b0;
        mem_rdy = 1'b1; mem_cplt = 1'b0; mem_data_out = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a downstream enable and capture what is being issued
    task automatic wait_issue(output logic ok, output logic [15:0] a, output logic w,
                              output logic [15:0] d);
        ok = 1'b0; a = '0; w = 1'b0; d = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_r_en || mem_w_en) begin
                ok = 1'b1; a = mem_addr; w = mem_w_en; d = mem_data_in;
            end else begin
                tick();
            end
        end
    endtask

    // From an ISSUE cycle: accept, then complete on the next edge; ends in the cplt cycle
    task automatic finish_txn(input logic [15:0] rdata);
        mem_rdy = 1'b1;
        tick();
        mem_cplt = 1'b1;
        mem_data_out = rdata;
        tick();
        mem_cplt = 1'b0;
        mem_data_out = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        total++; if (p0_rdy !== 1'b1) begin bad++; $display("FAIL reset_p0_rdy got=%b exp=1", p0_rdy); end
        total++; if (p1_rdy !== 1'b1) begin bad++; $display("FAIL reset_p1_rdy got=%b exp=1", p1_rdy); end
        total++; if ({p0_cplt, p1_cplt} !== 2'b00) begin bad++; $display("FAIL reset_cplt got=%b%b exp=00", p0_cplt, p1_cplt); end
        total++; if ({p0_data_out, p1_data_out} !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h %h exp=0", p0_data_out, p1_data_out); end
        total++; if ({mem_r_en, mem_w_en, mem_addr, mem_data_in} !== 34'h0) begin bad++; $display("FAIL reset_mem got=%b%b %h %h exp=0", mem_r_en, mem_w_en, mem_addr, mem_data_in); end
        total++; if ({err_timeout, err_stray} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b%b exp=00", err_timeout, err_stray); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        p0_addr = 16'h0040; p0_r_en = 1'b1;
        tick();                                  // edge 0: accept
        p0_r_en = 1'b0; p0_addr = 16'h0;
        total++; if (p0_rdy !== 1'b0) begin bad++; $display("FAIL sr_p0_busy got=%b exp=0", p0_rdy); end
        total++; if (mem_r_en !== 1'b0) begin bad++; $display("FAIL sr_en_cycle1 got=%b exp=0", mem_r_en); end
        tick();                                  // cycle 2: issue
        total++; if ({mem_r_en, mem_w_en} !== 2'b10) begin bad++; $display("FAIL sr_en_cycle2 got=%b%b exp=10", mem_r_en, mem_w_en); end
        total++; if (mem_addr !== 16'h0040) begin bad++; $display("FAIL sr_addr got=%h exp=0040", mem_addr); end
        tick();                                  // edge 2 accepted downstream
        mem_cplt = 1'b1; mem_data_out = 16'hBEEF;
        tick();                                  // edge 3: completion
        mem_cplt = 1'b0; mem_data_out = '0;
        total++; if (p0_cplt !== 1'b1) begin bad++; $display("FAIL sr_cplt got=%b exp=1", p0_cplt); end
        total++; if (p0_data_out !== 16'hBEEF) begin bad++; $display("FAIL sr_data got=%h exp=beef", p0_data_out); end
        total++; if (p0_rdy !== 1'b1) begin bad++; $display("FAIL sr_rdy_with_cplt got=%b exp=1", p0_rdy); end
        total++; if ({p1_cplt, p1_rdy, p1_data_out} !== {2'b01, 16'h0}) begin bad++; $display("FAIL sr_p1_untouched got=%b%b %h exp=01 0000", p1_cplt, p1_rdy, p1_data_out); end
        tick();
        total++; if (p0_cplt !== 1'b0) begin bad++; $display("FAIL sr_cplt_pulse got=%b exp=0", p0_cplt); end
        total++; if (p0_data_out !== 16'hBEEF) begin bad++; $display("FAIL sr_data_hold got=%h exp=beef", p0_data_out); end
    endtask

    task automatic test_contention();
        logic ok, w;
        logic [15:0] a, d;
        apply_reset();
        p0_addr = 16'h0010; p0_r_en = 1'b1;
        p1_addr = 16'h0020; p1_data_in = 16'h1234; p1_w_en = 1'b1;
        tick();
        p0_r_en = 1'b0; p1_w_en = 1'b0;
        wait_issue(ok, a, w, d);
        total++; if ({ok, a, w} !== {1'b1, 16'h0010, 1'b0}) begin bad++; $display("FAIL ct_first got=%b %h %b exp=1 0010 0", ok, a, w); end
        finish_txn(16'h5555);
        total++; if ({p0_cplt, p0_data_out} !== {1'b1, 16'h5555}) begin bad++; $display("FAIL ct_p0_done got=%b %h exp=1 5555", p0_cplt, p0_data_out); end
        wait_issue(ok, a, w, d);
        total++; if ({ok, a, w, d} !== {1'b1, 16'h0020, 1'b1, 16'h1234}) begin bad++; $display("FAIL ct_second got=%b %h %b %h exp=1 0020 1 1234", ok, a, w, d); end
        finish_txn(16'hFFFF);
        total++; if ({p1_cplt, p1_data_out} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL ct_p1_write got=%b %h exp=1 0000", p1_cplt, p1_data_out); end
        p0_r_en = 1'b1; p1_w_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] exp_a;
            exp_a = (k % 2 == 1) ? 16'h0020 : 16'h0010;
            wait_issue(ok, a, w, d);
            total++; if ({ok, a} !== {1'b1, exp_a}) begin bad++; $display("FAIL ct_rr%0d got=%b %h exp=1 %h", k, ok, a, exp_a); end
            finish_txn(16'h0);
        end
        p0_r_en = 1'b0; p1_w_en = 1'b0;
    endtask

    task automatic test_rdy_stall();
        logic ok, w;
        logic [15:0] a, d;
        int extra;
        apply_reset();
        mem_rdy = 1'b0;
        p0_addr = 16'h0077; p0_r_en = 1'b1;
        tick();
        p0_r_en = 1'b0;
        wait_issue(ok, a, w, d);
        for (int i = 0; i < 5; i++) begin
            total++; if ({mem_r_en, mem_addr} !== {1'b1, 16'h0077}) begin bad++; $display("FAIL stall_hold%0d got=%b %h exp=1 0077", i, mem_r_en, mem_addr); end
            tick();
        end
        mem_rdy = 1'b1;
        tick();                                  // single downstream accept
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_r_en || mem_w_en) extra++;
            tick();
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL stall_dup_issue got=%0d exp=0", extra); end
        mem_cplt = 1'b1; mem_data_out = 16'h0A0A;
        tick();
        mem_cplt = 1'b0;
        total++; if ({p0_cplt, p0_data_out} !== {1'b1, 16'h0A0A}) begin bad++; $display("FAIL stall_done got=%b %h exp=1 0a0a", p0_cplt, p0_data_out); end
    endtask

    task automatic test_timeout();
        logic ok, w;
        logic [15:0] a, d;
        int n;
        apply_reset();
        p0_addr = 16'h0100; p0_r_en = 1'b1;
        tick();
        p0_r_en = 1'b0;
        wait_issue(ok, a, w, d);
        finish_txn(16'hCAFE);
        total++; if (p0_data_out !== 16'hCAFE) begin bad++; $display("FAIL to_pre_read got=%h exp=cafe", p0_data_out); end
        p0_r_en = 1'b1;
        tick();
        p0_r_en = 1'b0;
        wait_issue(ok, a, w, d);
        tick();                                  // downstream accept, enter WAIT
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (p0_cplt) n = i;
        end
        total++; if (n !== 8) begin bad++; $display("FAIL to_latency got=%0d exp=8", n); end
        total++; if (p0_data_out !== 16'h0000) begin bad++; $display("FAIL to_data got=%h exp=0000", p0_data_out); end
        total++; if ({err_timeout, err_stray} !== 2'b10) begin bad++; $display("FAIL to_err got=%b%b exp=10", err_timeout, err_stray); end
        mem_cplt = 1'b1; mem_data_out = 16'h7777;
        tick();
        mem_cplt = 1'b0; mem_data_out = '0;
        total++; if ({err_stray, p0_cplt, p1_cplt} !== 3'b100) begin bad++; $display("FAIL to_stray got=%b%b%b exp=100", err_stray, p0_cplt, p1_cplt); end
        total++; if (p0_data_out !== 16'h0000) begin bad++; $display("FAIL to_stray_data got=%h exp=0000", p0_data_out); end
    endtask

    task automatic test_both_en();
        logic ok, w;
        logic [15:0] a, d;
        int extra;
        apply_reset();
        p1_addr = 16'h0200; p1_data_in = 16'h9999; p1_r_en = 1'b1; p1_w_en = 1'b1;
        tick();
        p1_r_en = 1'b0;
        p1_addr = 16'h0300; p1_data_in = 16'h7777;  // w_en still high while busy
        total++; if (p1_rdy !== 1'b0) begin bad++; $display("FAIL be_busy got=%b exp=0", p1_rdy); end
        tick();
        p1_w_en = 1'b0;
        wait_issue(ok, a, w, d);
        total++; if ({ok, mem_r_en, mem_w_en, a} !== {3'b110, 16'h0200}) begin bad++; $display("FAIL be_read got=%b%b%b %h exp=110 0200", ok, mem_r_en, mem_w_en, a); end
        finish_txn(16'h4321);
        total++; if ({p1_cplt, p1_data_out} !== {1'b1, 16'h4321}) begin bad++; $display("FAIL be_done got=%b %h exp=1 4321", p1_cplt, p1_data_out); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_r_en || mem_w_en) extra++;
            tick();
        end
        total++; if ({extra, p1_rdy} !== {32'd0, 1'b1}) begin bad++; $display("FAIL be_ignored got=%0d %b exp=0 1", extra, p1_rdy); end
    endtask

    // Runs straight after the timeout test so the sticky errors are set going in
    task automatic test_reset_mid();
        logic ok, w;
        logic [15:0] a, d;
        p0_addr = 16'h0400; p0_r_en = 1'b1; mem_rdy = 1'b1;
        tick();
        p0_r_en = 1'b0;
        wait_issue(ok, a, w, d);
        tick();                                  // now in WAIT
        total++; if (mem_addr !== 16'h0400) begin bad++; $display("FAIL rm_pre_addr got=%h exp=0400", mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({p0_rdy, p1_rdy, p0_cplt, p1_cplt} !== 4'b1100) begin bad++; $display("FAIL rm_ports got=%b%b%b%b exp=1100", p0_rdy, p1_rdy, p0_cplt, p1_cplt); end
        total++; if ({mem_r_en, mem_w_en, mem_addr} !== 18'h0) begin bad++; $display("FAIL rm_mem got=%b%b %h exp=0", mem_r_en, mem_w_en, mem_addr); end
        total++; if ({err_timeout, err_stray} !== 2'b00) begin bad++; $display("FAIL rm_err got=%b%b exp=00", err_timeout, err_stray); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (p0_cplt !== 1'b0) begin bad++; $display("FAIL rm_no_cplt got=%b exp=0", p0_cplt); end
        p0_addr = 16'h0500; p0_r_en = 1'b1;
        tick();
        p0_r_en = 1'b0;
        wait_issue(ok, a, w, d);
        total++; if ({ok, a} !== {1'b1, 16'h0500}) begin bad++; $display("FAIL rm_reissue got=%b %h exp=1 0500", ok, a); end
        finish_txn(16'h600D);
        total++; if ({p0_cplt, p0_data_out} !== {1'b1, 16'h600D}) begin bad++; $display("FAIL rm_done got=%b %h exp=1 600d", p0_cplt, p0_data_out); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_rdy_stall();
        test_both_en();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
